// File: rtl/ddc_accum_pkg.sv
// Shared constants, output word layout and length clamp
// for the DDC frame accumulator.
package ddc_accum_pkg;

  localparam int DIN_W     = 32;
  localparam int LOG_N_MAX = 16;
  localparam int ACC_W     = DIN_W + LOG_N_MAX;
  localparam int SEQ_W     = 16;
  localparam int LEN_W     = 5;

  typedef struct packed {
    logic [SEQ_W-1:0]   seq;
    logic signed [63:0] q;
    logic signed [63:0] i;
  } acc_word_t;

  function automatic logic [LEN_W-1:0] clamp_len(
    input logic [LEN_W-1:0] len
  );
    if (len > LEN_W'(LOG_N_MAX))
      return LEN_W'(LOG_N_MAX);
    return len;
  endfunction

endpackage

// File: rtl/ddc_accum_fifo.sv
// Two-entry output FIFO for accumulated frames.
// Pop and push on the same cycle is legal even when full.
module ddc_accum_fifo
  import ddc_accum_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  acc_word_t din,
  output logic      full,
  input  logic      pop,
  output acc_word_t dout,
  output logic      empty
);

  acc_word_t  mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] cnt;
  logic       do_pop;
  logic       do_push;

  assign full    = (cnt == 2'd2);
  assign empty   = (cnt == 2'd0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop)
        rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/ddc_accum.sv
// Integrates 2^len_log2 complex DDC samples per frame and
// emits one sequence-tagged sum per frame; never stalls input.
module ddc_accum
  import ddc_accum_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [63:0]        s_axis_ddc_tdata,
  input  logic               s_axis_ddc_tvalid,
  output logic               s_axis_ddc_tready,
  input  logic [LEN_W-1:0]   len_log2,
  input  logic               resync,
  output logic [127:0]       m_axis_acc_tdata,
  output logic               m_axis_acc_tvalid,
  input  logic               m_axis_acc_tready,
  output logic [SEQ_W-1:0]   m_axis_acc_tuser,
  output logic               overrun,
  input  logic               clr_overrun
);

  logic [LEN_W-1:0]        len_reg;
  logic [LOG_N_MAX-1:0]    cnt;
  logic signed [ACC_W-1:0] acc_i;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] sum_i;
  logic signed [ACC_W-1:0] sum_q;
  logic [DIN_W-1:0]        in_i;
  logic [DIN_W-1:0]        in_q;
  logic [SEQ_W-1:0]        seq;
  logic [31:0]             n_last;
  logic                    live;
  logic                    accept;
  logic                    last;
  logic                    dump;
  logic                    full;
  logic                    empty;
  logic                    pop;
  acc_word_t               din;
  acc_word_t               dout;

  assign in_i = s_axis_ddc_tdata[DIN_W-1:0];
  assign in_q = s_axis_ddc_tdata[63:32];

  // live marks that a reset has been seen; tready drops during rst
  assign s_axis_ddc_tready = live & ~rst;
  assign accept = s_axis_ddc_tvalid & ~rst & ~resync;

  assign n_last = (32'd1 << len_reg) - 32'd1;
  assign last   = ({{(32-LOG_N_MAX){1'b0}}, cnt} == n_last);
  assign dump   = accept & last;

  assign sum_i = acc_i
    + {{(ACC_W-DIN_W){in_i[DIN_W-1]}}, in_i};
  assign sum_q = acc_q
    + {{(ACC_W-DIN_W){in_q[DIN_W-1]}}, in_q};

  always_comb begin
    din     = '0;
    din.seq = seq;
    din.i   = {{(64-ACC_W){sum_i[ACC_W-1]}}, sum_i};
    din.q   = {{(64-ACC_W){sum_q[ACC_W-1]}}, sum_q};
  end

  assign pop = m_axis_acc_tready & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      live    <= 1'b1;
      len_reg <= clamp_len(len_log2);
      cnt     <= '0;
      acc_i   <= '0;
      acc_q   <= '0;
      seq     <= '0;
      overrun <= 1'b0;
    end else begin
      if (resync) begin
        len_reg <= clamp_len(len_log2);
        cnt     <= '0;
        acc_i   <= '0;
        acc_q   <= '0;
      end else if (accept) begin
        if (last) begin
          cnt   <= '0;
          acc_i <= '0;
          acc_q <= '0;
        end else begin
          cnt   <= cnt + LOG_N_MAX'(1);
          acc_i <= sum_i;
          acc_q <= sum_q;
        end
      end
      if (dump)
        seq <= seq + SEQ_W'(1);
      // a drop in the same cycle as a clear keeps the flag set
      if (dump && full)
        overrun <= 1'b1;
      else if (clr_overrun)
        overrun <= 1'b0;
    end
  end

  ddc_accum_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (dump),
    .din   (din),
    .full  (full),
    .pop   (pop),
    .dout  (dout),
    .empty (empty)
  );

  assign m_axis_acc_tvalid = ~empty;
  assign m_axis_acc_tdata  = {dout.q, dout.i};
  assign m_axis_acc_tuser  = dout.seq;

endmodule

// File: tb/tb_ddc_accum.sv
// Directed bench for ddc_accum: frame sums, drops,
// resync, mid-run reset and length clamping.
module tb_ddc_accum;

  logic         clk = 1'b0;
  logic         rst;
  logic [63:0]  s_tdata;
  logic         s_tvalid;
  logic         s_tready;
  logic [4:0]   len_log2;
  logic         resync;
  logic [127:0] m_tdata;
  logic         m_tvalid;
  logic         m_tready;
  logic [15:0]  m_tuser;
  logic         overrun;
  logic         clr_overrun;

  int total = 0;
  int bad   = 0;
  logic [15:0] seq_exp;

  ddc_accum dut (
    .clk               (clk),
    .rst               (rst),
    .s_axis_ddc_tdata  (s_tdata),
    .s_axis_ddc_tvalid (s_tvalid),
    .s_axis_ddc_tready (s_tready),
    .len_log2          (len_log2),
    .resync            (resync),
    .m_axis_acc_tdata  (m_tdata),
    .m_axis_acc_tvalid (m_tvalid),
    .m_axis_acc_tready (m_tready),
    .m_axis_acc_tuser  (m_tuser),
    .overrun           (overrun),
    .clr_overrun       (clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_resync(input logic [4:0] len);
    resync   = 1'b1;
    len_log2 = len;
    step();
    resync   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; len_log2 = 5'd2; resync = 1'b0;
    s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0;
    clr_overrun = 1'b0;
    step(); step();
    total++;
    if (s_tready !== 1'b0) begin
      bad++;
      $display("FAIL reset_tready got=%b want=0", s_tready);
    end
    total++;
    if ({m_tvalid, m_tdata, m_tuser, overrun} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b d=%h u=%h o=%b want 0",
               m_tvalid, m_tdata, m_tuser, overrun);
    end
    rst = 1'b0;
    #1;
    total++;
    if (s_tready !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_tready got=%b want=1", s_tready);
    end
    seq_exp = 16'd0;
  endtask

  task automatic test_n4();
    logic [127:0] exp;
    exp = {64'hFFFF_FFFF_FFFF_FFFC, 64'd4};
    m_tready = 1'b1;
    s_tdata  = {32'hFFFF_FFFF, 32'd1};
    s_tvalid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      total++;
      if (k % 4 == 0) begin
        if ({m_tvalid, m_tdata, m_tuser} !== {1'b1, exp, seq_exp}) begin
          bad++;
          $display("FAIL n4_word k=%0d got v=%b d=%h u=%0d want d=%h u=%0d",
                   k, m_tvalid, m_tdata, m_tuser, exp, seq_exp);
        end
        seq_exp++;
      end else if (m_tvalid !== 1'b0) begin
        bad++;
        $display("FAIL n4_gap k=%0d got valid=%b want=0", k, m_tvalid);
      end
    end
    s_tvalid = 1'b0;
    step();
  endtask

  task automatic test_len0_overrun();
    logic [15:0] s;
    s = seq_exp;
    do_resync(5'd0);
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      s_tdata = {32'd0, 32'(v)};
      step();
    end
    s_tvalid = 1'b0;
    total++;
    if ({m_tvalid, m_tuser, m_tdata, overrun} !==
        {1'b1, s, 128'd1, 1'b1}) begin
      bad++;
      $display("FAIL len0_head got v=%b u=%0d d=%h o=%b want u=%0d d=1 o=1",
               m_tvalid, m_tuser, m_tdata, overrun, s);
    end
    m_tready = 1'b1;
    step();
    total++;
    if ({m_tvalid, m_tuser, m_tdata} !== {1'b1, s + 16'd1, 128'd2}) begin
      bad++;
      $display("FAIL len0_second got v=%b u=%0d d=%h want u=%0d d=2",
               m_tvalid, m_tuser, m_tdata, s + 16'd1);
    end
    step();
    total++;
    if (m_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL len0_drained got valid=%b want=0", m_tvalid);
    end
    s_tdata = {32'd0, 32'd5}; s_tvalid = 1'b1;
    step();
    s_tvalid = 1'b0;
    total++;
    if ({m_tvalid, m_tuser, m_tdata} !== {1'b1, s + 16'd4, 128'd5}) begin
      bad++;
      $display("FAIL len0_gap_seq got v=%b u=%0d d=%h want u=%0d d=5",
               m_tvalid, m_tuser, m_tdata, s + 16'd4);
    end
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    total++;
    if ({overrun, m_tvalid} !== 2'b00) begin
      bad++;
      $display("FAIL clr_overrun got o=%b v=%b want 0 0", overrun, m_tvalid);
    end
    m_tready = 1'b0;
    s_tdata = {32'd0, 32'd7}; s_tvalid = 1'b1;
    step(); step();
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0; s_tvalid = 1'b0;
    total++;
    if ({overrun, m_tuser} !== {1'b1, s + 16'd5}) begin
      bad++;
      $display("FAIL set_wins got o=%b u=%0d want o=1 u=%0d",
               overrun, m_tuser, s + 16'd5);
    end
    m_tready = 1'b1;
    step(); step();
    total++;
    if (m_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL set_wins_drain got valid=%b want=0", m_tvalid);
    end
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    seq_exp = s + 16'd8;
  endtask

  task automatic test_resync();
    int early;
    early = 0;
    do_resync(5'd3);
    m_tready = 1'b1;
    s_tdata = {32'd0, 32'd1}; s_tvalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      if (m_tvalid !== 1'b0) early++;
    end
    resync = 1'b1; len_log2 = 5'd1;
    s_tdata = {32'd0, 32'd100};
    step();
    resync = 1'b0;
    if (m_tvalid !== 1'b0) early++;
    s_tdata = {32'd0, 32'd10};
    step();
    if (m_tvalid !== 1'b0) early++;
    total++;
    if (early != 0) begin
      bad++;
      $display("FAIL resync_no_dump got early=%0d want=0", early);
    end
    s_tdata = {32'd0, 32'd20};
    step();
    s_tvalid = 1'b0;
    total++;
    if ({m_tvalid, m_tuser, m_tdata} !== {1'b1, seq_exp, 128'd30}) begin
      bad++;
      $display("FAIL resync_frame got v=%b u=%0d d=%h want u=%0d d=30",
               m_tvalid, m_tuser, m_tdata, seq_exp);
    end
    seq_exp++;
    step();
  endtask

  task automatic test_reset_mid();
    do_resync(5'd1);
    m_tready = 1'b0;
    s_tdata = {32'd0, 32'd3}; s_tvalid = 1'b1;
    for (int k = 0; k < 7; k++) step();
    s_tvalid = 1'b0;
    total++;
    if ({m_tvalid, overrun} !== 2'b11) begin
      bad++;
      $display("FAIL pre_reset got v=%b o=%b want 1 1", m_tvalid, overrun);
    end
    rst = 1'b1; len_log2 = 5'd2;
    #1;
    total++;
    if (s_tready !== 1'b0) begin
      bad++;
      $display("FAIL mid_rst_tready got=%b want=0", s_tready);
    end
    step();
    total++;
    if ({m_tvalid, m_tuser, overrun, m_tdata} !== '0) begin
      bad++;
      $display("FAIL mid_rst_state got v=%b u=%0d o=%b d=%h want 0",
               m_tvalid, m_tuser, overrun, m_tdata);
    end
    rst = 1'b0;
    #1;
    total++;
    if (s_tready !== 1'b1) begin
      bad++;
      $display("FAIL mid_rst_release got=%b want=1", s_tready);
    end
    m_tready = 1'b1;
    s_tdata = {32'hFFFF_FFFF, 32'd1}; s_tvalid = 1'b1;
    for (int k = 0; k < 4; k++) step();
    s_tvalid = 1'b0;
    total++;
    if ({m_tvalid, m_tuser, m_tdata} !==
        {1'b1, 16'd0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd4}) begin
      bad++;
      $display("FAIL mid_rst_frame got v=%b u=%0d d=%h want u=0 I=4 Q=-4",
               m_tvalid, m_tuser, m_tdata);
    end
    seq_exp = 16'd1;
    step();
  endtask

  task automatic test_long_clamp();
    do_resync(5'd20);
    m_tready = 1'b1;
    s_tdata = {32'h8000_0000, 32'h7FFF_FFFF}; s_tvalid = 1'b1;
    for (int k = 0; k < 65535; k++) step();
    total++;
    if (m_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL long_early got valid=%b want=0", m_tvalid);
    end
    step();
    s_tvalid = 1'b0;
    total++;
    if ({m_tvalid, m_tuser, m_tdata} !==
        {1'b1, seq_exp, 64'hFFFF_8000_0000_0000,
         64'h0000_7FFF_FFFF_0000}) begin
      bad++;
      $display("FAIL long_sum got v=%b u=%0d d=%h want u=%0d",
               m_tvalid, m_tuser, m_tdata, seq_exp);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_n4();
    test_len0_overrun();
    test_resync();
    test_reset_mid();
    test_long_clamp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
